uart_rx_fifo: RTL and testbench

- Robust UART receiver: 16x oversampled, 3-sample majority vote per bit, 8N1 framing.
- Adds start-glitch rejection, framing-error and break detection, and a DEPTH-entry show-ahead receive FIFO with overrun flag.
- Sits between the board RX pin and the CPU I/O bus. Replaces the single-byte receive path where the CPU cannot service every byte in time.

---
 rtl/uart_rx_fifo.sv | 118 +++++++++++
 tb/tb_uart_rx_fifo.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampled 8N1 UART receiver with majority voting, break/framing detection
// and a show-ahead receive FIFO with sticky overrun.
module uart_rx_fifo #(
    parameter int CLKFREQ = 36000000,
    parameter int BAUD    = 115200,
    parameter int DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     resetq,
    input  logic                     uart_rx,
    input  logic                     rd,
    input  logic                     err_clr,
    output logic                     valid,
    output logic [7:0]               data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    output logic                     frame_err,
    output logic                     brk
);
    localparam int DIV = CLKFREQ / (16 * BAUD);
    localparam int CW  = $clog2(DIV + 1);
    localparam int AW  = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;

    state_t         state, state_n;
    logic           s1, rxs;
    logic [CW-1:0]  div_cnt;
    logic           tick;
    logic [3:0]     phase;
    logic [2:0]     bitidx;
    logic [7:0]     shifter;
    logic           s7, s8, maj;
    logic           push, ferr_set, brk_set;
    logic           pop, wr, full;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wp, rp;

    always_ff @(posedge clk or negedge resetq)
        if (!resetq) {s1, rxs} <= 2'b11;
        else         {s1, rxs} <= {uart_rx, s1};

    assign tick = div_cnt == CW'(DIV - 1);

    always_ff @(posedge clk or negedge resetq)
        if (!resetq) div_cnt <= '0;
        else         div_cnt <= tick ? '0 : div_cnt + CW'(1);

    // vote uses the two stored samples plus the live phase-9 sample
    assign maj = (s7 & s8) | (s7 & rxs) | (s8 & rxs);

    always_ff @(posedge clk or negedge resetq)
        if (!resetq) state <= IDLE;
        else         state <= state_n;

    always_comb begin
        state_n = state;
        if (tick)
            case (state)
                IDLE:    state_n = rxs ? IDLE : START;
                START:   state_n = (phase == 4'd9 && maj) ? IDLE :
                                   (phase == 4'd15) ? DATA : START;
                DATA:    state_n = (phase == 4'd15 && bitidx == 3'd7) ? STOP : DATA;
                STOP:    state_n = (phase != 4'd9) ? STOP : maj ? IDLE : WAITHI;
                WAITHI:  state_n = rxs ? IDLE : WAITHI;
                default: state_n = IDLE;
            endcase
    end

    always_comb begin
        push     = tick && state == STOP && phase == 4'd9 && maj;
        ferr_set = tick && state == STOP && phase == 4'd9 && !maj;
        brk_set  = ferr_set && shifter == 8'd0;
    end

    // phase wraps 15->0 on its own, which is exactly the START->DATA and DATA->STOP entry value
    always_ff @(posedge clk or negedge resetq)
        if (!resetq) begin
            phase   <= '0;
            bitidx  <= '0;
            shifter <= '0;
            s7      <= 1'b1;
            s8      <= 1'b1;
        end else if (tick) begin
            phase <= (state == IDLE) ? 4'd0 : phase + 4'd1;
            if (phase == 4'd7) s7 <= rxs;
            if (phase == 4'd8) s8 <= rxs;
            if (state == START && phase == 4'd15) bitidx <= '0;
            if (state == DATA && phase == 4'd15) bitidx <= bitidx + 3'd1;
            if (state == DATA && phase == 4'd9) shifter <= {maj, shifter[7:1]};
        end

    assign full  = count == (AW + 1)'(DEPTH);
    assign valid = count != '0;
    assign pop   = rd && valid;
    assign wr    = push && (!full || pop);
    assign data  = valid ? mem[rp] : 8'd0;

    always_ff @(posedge clk)
        if (wr) mem[wp] <= shifter;

    always_ff @(posedge clk or negedge resetq)
        if (!resetq) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            brk       <= 1'b0;
        end else begin
            wp        <= wp + AW'(wr);
            rp        <= rp + AW'(pop);
            count     <= count + (AW + 1)'(wr) - (AW + 1)'(pop);
            overrun   <= (push && !wr) || (overrun && !err_clr);
            frame_err <= ferr_set || (frame_err && !err_clr);
            brk       <= brk_set || (brk && !err_clr);
        end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table vectors, corner sequences and random frames checked against a
// queue-based model of the receive FIFO and its sticky flags.
module tb_uart_rx_fifo;
    localparam int DEPTH  = 8;
    localparam int DIV    = 19;
    localparam int BIT    = 16 * DIV;
    // first tick after the falling edge, start bit, 8 data bits, then stop-bit phase 9
    localparam int PUSH_C = (1 + 16 + 8 * 16 + 9 + 1) * DIV;

    logic       clk = 0, resetq = 0, uart_rx = 1, rd = 0, err_clr = 0;
    logic       valid, overrun, frame_err, brk;
    logic [7:0] data;
    logic [3:0] count;

    uart_rx_fifo #(.CLKFREQ(36000000), .BAUD(115200), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetq(resetq), .uart_rx(uart_rx), .rd(rd), .err_clr(err_clr),
        .valid(valid), .data(data), .count(count),
        .overrun(overrun), .frame_err(frame_err), .brk(brk)
    );

    always #5 clk = ~clk;

    int   bcnt;
    logic btick;
    assign btick = bcnt == DIV - 1;
    always @(posedge clk or negedge resetq)
        if (!resetq) bcnt <= 0;
        else         bcnt <= btick ? 0 : bcnt + 1;

    logic [7:0] mq[$];
    logic       m_ovr = 0, m_fe = 0, m_brk = 0;
    int         checks = 0, errors = 0;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         npop;
        int         cnt;
        logic [7:0] d;
        logic       fe;
        logic       br;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // applies inputs for the next edge and advances the model by the same edge
    task automatic step(input logic rxv, input logic rdv, input logic clrv,
                        input logic pushv, input logic [7:0] pb, input logic fev);
        uart_rx = rxv;
        rd      = rdv;
        err_clr = clrv;
        if (clrv) {m_ovr, m_fe, m_brk} = 3'b000;
        if (rdv && mq.size() > 0) void'(mq.pop_front());
        if (pushv) begin
            if (mq.size() < DEPTH) mq.push_back(pb);
            else m_ovr = 1;
        end
        if (fev) begin
            m_fe = 1;
            if (pb == 8'd0) m_brk = 1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1, 0, 0, 0, 8'd0, 0);
    endtask

    task automatic pop_n(input int n);
        repeat (n) step(1, 1, 0, 0, 8'd0, 0);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_cnt"}, count, mq.size());
        chk({tag, "_valid"}, valid, mq.size() > 0);
        chk({tag, "_data"}, data, mq.size() > 0 ? mq[0] : 8'd0);
        chk({tag, "_ovr"}, overrun, m_ovr);
        chk({tag, "_fe"}, frame_err, m_fe);
        chk({tag, "_brk"}, brk, m_brk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic rd_push,
                              input int glitch_c, input int stop_len, input int clr_c);
        logic [9:0] bits;
        logic       lv;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < DIV && !btick; i++) idle(1);
        for (int c = 0; c < 9 * BIT + stop_len; c++) begin
            lv = (c >= 9 * BIT) ? stop : bits[c / BIT];
            if (c == glitch_c) lv = 0;
            step(lv, rd_push && c == PUSH_C, c == clr_c, stop && c == PUSH_C, b,
                 !stop && c == PUSH_C);
            if (c == PUSH_C - 1) chk("pre_push_cnt", count, mq.size());
            if (c == PUSH_C) chk("push_cnt", count, mq.size());
        end
        idle(40);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{8'h55, 1'b1, 0, 1, 8'h55, 1'b0, 1'b0};
        tbl[1] = '{8'hC3, 1'b1, 1, 1, 8'hC3, 1'b0, 1'b0};
        tbl[2] = '{8'hA3, 1'b0, 1, 0, 8'h00, 1'b1, 1'b0};
        tbl[3] = '{8'h00, 1'b0, 0, 0, 8'h00, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_cnt", count, 0);
        chk("rst_flags", {overrun, frame_err, brk}, 0);
        resetq = 1;
        idle(50);

        for (int i = 0; i < 4; i++) begin
            send_frame(tbl[i].b, tbl[i].stop, 0, -1, BIT, -1);
            pop_n(tbl[i].npop);
            chk($sformatf("v%0d_cnt", i), count, tbl[i].cnt);
            chk($sformatf("v%0d_valid", i), valid, tbl[i].cnt != 0);
            chk($sformatf("v%0d_data", i), data, tbl[i].d);
            chk($sformatf("v%0d_fe", i), frame_err, tbl[i].fe);
            chk($sformatf("v%0d_brk", i), brk, tbl[i].br);
        end
        step(1, 0, 1, 0, 8'd0, 0);
        check_model("clr");

        // break held well past the frame; cleared mid-hold, must not fire again
        send_frame(8'h00, 0, 0, -1, 4 * BIT, 11 * BIT);
        check_model("brk_once");
        send_frame(8'h3C, 1, 0, -1, BIT, -1);
        chk("b3c_data", data, 8'h3C);
        pop_n(1);

        repeat (50) step(0, 0, 0, 0, 8'd0, 0);
        idle(400);
        check_model("glitch_idle");
        send_frame(8'hFF, 1, 0, 2 + 3 * BIT + 8 * DIV, BIT, -1);
        chk("glitch_ff", data, 8'hFF);
        check_model("glitch_ff");
        pop_n(1);

        for (int k = 1; k <= 9; k++) send_frame(8'(k), 1, 0, -1, BIT, -1);
        chk("ovr_cnt", count, 8);
        chk("ovr_flag", overrun, 1);
        chk("ovr_head", data, 8'h01);
        step(1, 0, 1, 0, 8'd0, 0);
        chk("ovr_clr", overrun, 0);
        send_frame(8'h99, 1, 1, -1, BIT, -1);
        chk("full_pop_cnt", count, 8);
        chk("full_pop_ovr", overrun, 0);
        for (int k = 2; k <= 6; k++) begin
            chk($sformatf("rd_%0d", k), data, 8'(k));
            pop_n(1);
        end
        check_model("drain");

        for (int i = 0; i < DIV && !btick; i++) idle(1);
        for (int c = 0; c < 1500; c++) step(c < BIT ? 1'b0 : 1'b1, 0, 0, 0, 8'd0, 0);
        resetq = 0;
        #1;
        mq.delete();
        {m_ovr, m_fe, m_brk} = 3'b000;
        check_model("midrst");
        @(negedge clk);
        resetq = 1;
        idle(20);
        send_frame(8'h7E, 1, 0, -1, BIT, -1);
        chk("post_rst", data, 8'h7E);
        check_model("post_rst");

        for (int i = 0; i < 3; i++) begin
            pop_n($urandom_range(0, 2));
            send_frame(8'($urandom), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                       -1, BIT, -1);
            check_model($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
